// File: rtl/multiplex.sv
// multiplex: N-to-1 word selector with a combinational output and an
// enabled, registered copy carrying a one-cycle valid strobe.
module multiplex #(
  parameter int Width       = 8,
  parameter int AddressSize = 2
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [Width*(2**AddressSize)-1:0] D,
  input  logic [AddressSize-1:0]            S,
  input  logic                              EN,
  output logic [Width-1:0]                  Q,
  output logic [Width-1:0]                  QR,
  output logic                              VALID
);

  localparam int NumWords = 2**AddressSize;

  // Flat bus viewed as an array of words; word 0 occupies the LSBs.
  logic [Width-1:0] wordArray [NumWords];
  logic [Width-1:0] capturedWord_q;
  logic [Width-1:0] capturedWord_d;
  logic             valid_q;
  logic             valid_d;

  genvar k;
  generate
    for (k = 0; k < NumWords; k++) begin : gSlice
      assign wordArray[k] = D[k*Width +: Width];
    end
  endgenerate

  // Every select value names a real word, so no default is needed.
  assign Q = wordArray[S];

  // Capture on enable, otherwise hold; valid simply mirrors the enable.
  always_comb begin
    capturedWord_d = capturedWord_q;
    valid_d        = EN;
    if (EN) begin
      capturedWord_d = Q;
    end
  end

  // Registered path; reset clears word and strobe regardless of the clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      capturedWord_q <= '0;
      valid_q        <= 1'b0;
    end else begin
      capturedWord_q <= capturedWord_d;
      valid_q        <= valid_d;
    end
  end

  assign QR    = capturedWord_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_multiplex.sv
// tb_multiplex: directed literal checks plus randomized stimulus compared
// against a shift-and-mask reference model of the selector.
`timescale 1ns/1ps
module tb_multiplex;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] dA    = '0;
  logic [1:0]  sA    = '0;
  logic        enA   = 1'b0;
  logic [7:0]  qA;
  logic [7:0]  qrA;
  logic        validA;

  logic [31:0] dB    = '0;
  logic [2:0]  sB    = '0;
  logic        enB   = 1'b0;
  logic [3:0]  qB;
  logic [3:0]  qrB;
  logic        validB;

  int checkCount   = 0;
  int failureCount = 0;
  bit autoCheck    = 1'b0;

  logic [7:0] expQR    = '0;
  logic       expValid = 1'b0;

  multiplex #(.Width(8), .AddressSize(2)) dutA (
    .CLK(CLK), .RST_N(RST_N), .D(dA), .S(sA), .EN(enA),
    .Q(qA), .QR(qrA), .VALID(validA)
  );

  multiplex #(.Width(4), .AddressSize(3)) dutB (
    .CLK(CLK), .RST_N(RST_N), .D(dB), .S(sB), .EN(enB),
    .Q(qB), .QR(qrB), .VALID(validB)
  );

  always #5 CLK = ~CLK;

  // Reference selection: shift the wanted word down and mask it off.
  function automatic logic [7:0] refMuxA(input logic [31:0] d, input logic [1:0] s);
    logic [31:0] shifted;
    shifted = d >> (int'(s) * 8);
    return shifted[7:0];
  endfunction

  function automatic logic [3:0] refMuxB(input logic [31:0] d, input logic [2:0] s);
    logic [31:0] shifted;
    shifted = d >> (int'(s) * 4);
    return shifted[3:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failureCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] s, input logic en);
    dA  = d;
    sA  = s;
    enA = en;
  endtask

  // Behavioural expectation for the registered path of instance A.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      expQR    <= '0;
      expValid <= 1'b0;
    end else begin
      expValid <= enA;
      if (enA) expQR <= refMuxA(dA, sA);
    end
  end

  // Cycle-by-cycle comparison during the randomized phase.
  always @(posedge CLK) begin
    #1;
    if (autoCheck) begin
      checkOutput("rand_Q_A", 32'(qA), 32'(refMuxA(dA, sA)));
      checkOutput("rand_QR_A", 32'(qrA), 32'(expQR));
      checkOutput("rand_VALID_A", 32'(validA), 32'(expValid));
      checkOutput("rand_Q_B", 32'(qB), 32'(refMuxB(dB, sB)));
    end
  end

  initial begin
    logic [7:0] seqExp [4];
    seqExp[0] = 8'hEF; seqExp[1] = 8'hBE; seqExp[2] = 8'hAD; seqExp[3] = 8'hDE;

    #1 RST_N = 1'b0;
    applyStimulus(32'hDEADBEEF, 2'd0, 1'b0);
    @(negedge CLK);
    checkOutput("reset_QR", 32'(qrA), 32'h0);
    checkOutput("reset_VALID", 32'(validA), 32'h0);

    // Combinational sweep while reset is held.
    for (int s = 0; s < 4; s++) begin
      sA = 2'(s);
      #1;
      checkOutput($sformatf("comb_Q_S%0d", s), 32'(qA), 32'(seqExp[s]));
      checkOutput($sformatf("model_Q_S%0d", s), 32'(refMuxA(dA, sA)), 32'(seqExp[s]));
    end

    sA = 2'd2;
    dA = 32'h00FF0000;
    #1;
    checkOutput("D_change_Q", 32'(qA), 32'hFF);
    checkOutput("D_change_QR", 32'(qrA), 32'h0);

    // Release reset and capture a single word.
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(32'hDEADBEEF, 2'd1, 1'b1);
    @(posedge CLK); #1;
    checkOutput("capture_QR", 32'(qrA), 32'hBE);
    checkOutput("capture_VALID", 32'(validA), 32'h1);
    @(negedge CLK);
    enA = 1'b0;
    @(posedge CLK); #1;
    checkOutput("hold_QR", 32'(qrA), 32'hBE);
    checkOutput("hold_VALID", 32'(validA), 32'h0);

    // Back-to-back captures stepping through every word.
    for (int s = 0; s < 4; s++) begin
      @(negedge CLK);
      applyStimulus(32'hDEADBEEF, 2'(s), 1'b1);
      @(posedge CLK); #1;
      checkOutput($sformatf("burst_QR_%0d", s), 32'(qrA), 32'(seqExp[s]));
      checkOutput($sformatf("burst_VALID_%0d", s), 32'(validA), 32'h1);
    end
    @(negedge CLK);
    sA = 2'd2;
    @(posedge CLK); #1;
    checkOutput("pre_reset_QR", 32'(qrA), 32'hAD);

    // Asynchronous reset between edges.
    @(negedge CLK);
    enA = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checkOutput("async_reset_QR", 32'(qrA), 32'h0);
    checkOutput("async_reset_VALID", 32'(validA), 32'h0);
    sA = 2'd3;
    #1;
    checkOutput("async_reset_Q", 32'(qA), 32'hDE);
    enA = 1'b1;
    @(posedge CLK); #1;
    checkOutput("reset_hold_QR", 32'(qrA), 32'h0);
    checkOutput("reset_hold_VALID", 32'(validA), 32'h0);

    // Wider select, narrower words.
    dB = 32'h76543210;
    for (int s = 0; s < 8; s++) begin
      sB = 3'(s);
      #1;
      checkOutput($sformatf("B_Q_S%0d", s), 32'(qB), 32'(s));
    end

    // Randomized phase with occasional asynchronous reset pulses.
    @(negedge CLK);
    RST_N = 1'b1;
    enA   = 1'b0;
    @(negedge CLK);
    autoCheck = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      applyStimulus($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      dB  = $urandom;
      sB  = 3'($urandom_range(0, 7));
      enB = 1'($urandom_range(0, 1));
      RST_N = ($urandom_range(0, 19) != 0);
    end
    @(negedge CLK);
    autoCheck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failureCount);
    $finish;
  end

endmodule
